// File: rtl/dtpu_outfifo_axis.sv
// dtpu_outfifo_axis: dtpu_core result FIFO drained as AXI4-Stream master with tlast packetising (core write/full/eop in; m_axis_* out; level/overflow debug)
module dtpu_outfifo_axis #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH = 16,
  parameter int PKT_LEN = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   outfifo_din,
  input  logic                    outfifo_write,
  output logic                    outfifo_is_full,
  input  logic                    eop,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [ADDR_W:0]         level,
  output logic                    overflow
);
  localparam int CNT_W = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_LEN-1);
  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] beat_cnt;
  logic push, pop, last_in;
  assign push = outfifo_write && level != FULL;
  assign pop = m_axis_tvalid && m_axis_tready;
  assign last_in = beat_cnt == LAST_BEAT || eop;
  assign outfifo_is_full = level == FULL;
  assign m_axis_tvalid = level != '0;
  assign m_axis_tdata = mem[rd_ptr][DATA_WIDTH-1:0];
  assign m_axis_tlast = m_axis_tvalid && mem[rd_ptr][DATA_WIDTH];
  assign m_axis_tkeep = {(DATA_WIDTH/8){m_axis_tvalid}};
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {last_in, outfifo_din};
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      beat_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (push) beat_cnt <= last_in ? '0 : beat_cnt + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
      if (outfifo_write && !push) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dtpu_outfifo_axis.sv
// tb_dtpu_outfifo_axis: directed scoreboard bench for dtpu_outfifo_axis
module tb_dtpu_outfifo_axis;
  localparam int DW = 64;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [DW-1:0] outfifo_din = '0;
  logic outfifo_write = 1'b0;
  logic outfifo_is_full;
  logic eop = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic m_axis_tvalid;
  logic m_axis_tready = 1'b0;
  logic m_axis_tlast;
  logic [DW/8-1:0] m_axis_tkeep;
  logic [4:0] level;
  logic overflow;
  int checks = 0;
  int errors = 0;
  logic [DW:0] q[$];
  bit ovf_exp = 1'b0;
  dtpu_outfifo_axis #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PKT_LEN(8)) dut (
    .clk(clk), .reset(reset), .outfifo_din(outfifo_din), .outfifo_write(outfifo_write),
    .outfifo_is_full(outfifo_is_full), .eop(eop), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tkeep(m_axis_tkeep), .level(level), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [DW:0] obs, logic [DW:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(bit wr, logic [DW-1:0] d, bit e, bit rdy, bit exp_last);
    bit full_b;
    outfifo_write = wr;
    outfifo_din = d;
    eop = e;
    m_axis_tready = rdy;
    @(negedge clk);
    full_b = q.size() == DEPTH;
    chk("level", level, q.size());
    chk("tvalid", m_axis_tvalid, q.size() != 0);
    chk("full", outfifo_is_full, full_b);
    chk("overflow", overflow, ovf_exp);
    chk("tkeep", m_axis_tkeep, q.size() != 0 ? 'hff : 0);
    if (q.size() != 0) chk("head", {m_axis_tlast, m_axis_tdata}, q[0]);
    else chk("tlast_idle", m_axis_tlast, 0);
    if (q.size() != 0 && rdy) void'(q.pop_front());
    if (wr && !full_b) q.push_back({exp_last, d});
    if (wr && full_b) ovf_exp = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    for (int i = 0; i < 64 && q.size() != 0; i++) step(0, '0, 0, 1, 0);
    chk("drain_timeout", q.size(), 0);
    step(0, '0, 0, 1, 0);
  endtask
  task automatic do_reset(int n);
    reset = 1'b1;
    outfifo_write = 1'b1;
    outfifo_din = '1;
    eop = 1'b1;
    m_axis_tready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_level", level, 0);
    chk("rst_full", outfifo_is_full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tkeep", m_axis_tkeep, 0);
    reset = 1'b0;
    outfifo_write = 1'b0;
    eop = 1'b0;
    q.delete();
    ovf_exp = 1'b0;
  endtask
  initial begin
    int n, cyc;
    do_reset(2);
    step(0, '0, 0, 1, 0);
    step(1, {8{8'h11}}, 0, 0, 0);
    step(1, {8{8'h22}}, 0, 0, 0);
    step(1, {8{8'h33}}, 0, 0, 0);
    step(0, '0, 0, 0, 0);
    step(0, '0, 0, 0, 0);
    drain();
    do_reset(1);
    for (int i = 1; i <= 9; i++) step(1, {8{8'(i * 8'h11)}}, 0, 1, i == 8);
    drain();
    do_reset(1);
    step(1, 64'hA1, 0, 1, 0);
    step(1, 64'hA2, 0, 1, 0);
    step(1, 64'hA3, 1, 1, 1);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) step(0, '0, 1, 1, 0);
      step(1, 64'hB0 + 64'(i), 0, 1, i == 7);
    end
    drain();
    do_reset(1);
    for (int i = 1; i <= 16; i++) step(1, 64'(i), 0, 0, i % 8 == 0);
    step(1, 64'd17, 0, 1, 0);
    drain();
    do_reset(1);
    n = 0;
    cyc = 0;
    while (n < 40 && cyc < 300) begin
      if (q.size() < DEPTH) begin
        step(1, {$urandom, $urandom}, 0, cyc % 2 == 0, n % 8 == 7);
        n++;
      end else step(0, '0, 0, cyc % 2 == 0, 0);
      cyc++;
    end
    chk("wrap_count", n, 40);
    do_reset(1);
    step(0, '0, 0, 1, 0);
    step(1, 64'hC1, 0, 1, 0);
    step(1, 64'hC2, 0, 1, 0);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
